// File: rtl/equiv_pkg.sv
// Shared constants for the equivalence stimulus scheduler: LFSR polynomial,
// default seed, stimulus field layout and FSM state encoding.
package equiv_pkg;

    // Right-shifting Galois taps for x^64+x^63+x^61+x^60+1 (exponent-1 bit positions).
    localparam logic [63:0] LFSR_POLY  = 64'hD800_0000_0000_0000;
    localparam logic [63:0] DEF_SEED_C = 64'h1;

    localparam int W0_OFF = 0;
    localparam int W0_W   = 18;
    localparam int W1_OFF = 18;
    localparam int W1_W   = 9;
    localparam int W2_OFF = 27;
    localparam int W2_W   = 8;
    localparam int W3_OFF = 35;
    localparam int W3_W   = 3;
    localparam int W4_OFF = 38;
    localparam int W4_W   = 11;
    localparam int VEC_W  = 49;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/equiv_lfsr64.sv
// 64-bit Galois LFSR with synchronous seed load and single-step enable.
module equiv_lfsr64
    import equiv_pkg::*;
#(
    parameter logic [63:0] SEED_RST = DEF_SEED_C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [63:0] seed,
    input  logic        step,
    output logic [63:0] state
);

    // Load has priority so a new run always starts from the requested seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED_RST;
        end else if (load) begin
            state <= seed;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/equiv_stim_sched.sv
// Seed-replayable stimulus scheduler and latency-aligned y_1/y_2 comparator
// for the dual-instance equivalence harness.
module equiv_stim_sched
    import equiv_pkg::*;
#(
    parameter int          Y_W      = 91,
    parameter int          LAT      = 1,
    parameter int          CNT_W    = 16,
    parameter logic [63:0] DEF_SEED = DEF_SEED_C
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop_on_fail,
    input  logic [63:0]         seed,
    input  logic [CNT_W-1:0]    num_vec,
    output logic [W0_W-1:0]     wire0,
    output logic signed [W1_W-1:0] wire1,
    output logic signed [W2_W-1:0] wire2,
    output logic signed [W3_W-1:0] wire3,
    output logic [W4_W-1:0]     wire4,
    input  logic [Y_W-1:0]      y_1,
    input  logic [Y_W-1:0]      y_2,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CNT_W-1:0]    vec_cnt,
    output logic [CNT_W-1:0]    mismatch_cnt,
    output logic [CNT_W-1:0]    fail_idx,
    output logic [Y_W-1:0]      fail_y1,
    output logic [Y_W-1:0]      fail_y2,
    output state_t              dbg_state
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // start is a single-cycle request with no ready: it is accepted only when
    // the FSM is IDLE or DONE and silently dropped while busy.

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   num_vec_q;
    logic [CNT_W-1:0]   issue_cnt_q;
    logic               stop_q;
    logic [VEC_W-1:0]   last_q;
    logic [63:0]        lfsr_state;
    logic [63:0]        seed_eff;
    logic [VEC_W-1:0]   cur_vec;
    logic               start_ok;
    logic               issue;
    logic               last_issue;
    logic               cmp_v;
    logic [CNT_W-1:0]   cmp_idx;
    logic               pending;
    logic               cmp_en;
    logic               mism;
    logic               stop_now;
    logic               unused_lfsr_hi;

    assign start_ok   = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign issue      = (state_q == ST_RUN);
    assign last_issue = issue && (issue_cnt_q == num_vec_q - CNT_ONE);
    assign seed_eff   = (seed == 64'd0) ? DEF_SEED : seed;

    equiv_lfsr64 #(
        .SEED_RST (DEF_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_ok),
        .seed  (seed_eff),
        .step  (issue),
        .state (lfsr_state)
    );

    assign unused_lfsr_hi = ^lfsr_state[63:VEC_W];

    // Issue index and valid ride an LAT-deep pipe so each compare lines up
    // with the response to the vector that produced it.
    generate
        if (LAT == 0) begin : g_lat0
            assign cmp_v   = issue;
            assign cmp_idx = issue_cnt_q;
            assign pending = 1'b0;
        end else begin : g_pipe
            logic [LAT-1:0]   v_q;
            logic [CNT_W-1:0] idx_q [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        idx_q[i] <= '0;
                    end
                end else if (start_ok) begin
                    v_q <= '0;
                end else begin
                    v_q[0]   <= issue;
                    idx_q[0] <= issue_cnt_q;
                    for (int i = 1; i < LAT; i++) begin
                        v_q[i]   <= v_q[i-1];
                        idx_q[i] <= idx_q[i-1];
                    end
                end
            end

            // Anything still in flight behind the stage currently comparing.
            always_comb begin
                pending = 1'b0;
                for (int i = 0; i < LAT - 1; i++) begin
                    pending = pending | v_q[i];
                end
            end

            assign cmp_v   = v_q[LAT-1];
            assign cmp_idx = idx_q[LAT-1];
        end
    endgenerate

    assign cmp_en   = cmp_v && (state_q == ST_RUN || state_q == ST_DRAIN);
    assign mism     = cmp_en && (y_1 != y_2);
    assign stop_now = mism && stop_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (num_vec == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_now) begin
                    state_d = ST_DONE;
                end else if (last_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (stop_now || !pending) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_vec_q    <= '0;
            stop_q       <= 1'b0;
            issue_cnt_q  <= '0;
            last_q       <= '0;
            vec_cnt      <= '0;
            mismatch_cnt <= '0;
            fail_idx     <= '0;
            fail_y1      <= '0;
            fail_y2      <= '0;
        end else if (start_ok) begin
            num_vec_q    <= num_vec;
            stop_q       <= stop_on_fail;
            issue_cnt_q  <= '0;
            vec_cnt      <= '0;
            mismatch_cnt <= '0;
            fail_idx     <= '0;
            fail_y1      <= '0;
            fail_y2      <= '0;
        end else begin
            if (issue) begin
                issue_cnt_q <= issue_cnt_q + CNT_ONE;
                last_q      <= lfsr_state[VEC_W-1:0];
            end
            if (cmp_en) begin
                vec_cnt <= vec_cnt + CNT_ONE;
            end
            if (mism) begin
                if (mismatch_cnt != '1) begin
                    mismatch_cnt <= mismatch_cnt + CNT_ONE;
                end
                if (mismatch_cnt == '0) begin
                    fail_idx <= cmp_idx;
                    fail_y1  <= y_1;
                    fail_y2  <= y_2;
                end
            end
        end
    end

    // Outside RUN the bus holds the last issued vector (zero after reset).
    assign cur_vec = (state_q == ST_RUN) ? lfsr_state[VEC_W-1:0] : last_q;

    assign wire0 = cur_vec[W0_OFF +: W0_W];
    assign wire1 = cur_vec[W1_OFF +: W1_W];
    assign wire2 = cur_vec[W2_OFF +: W2_W];
    assign wire3 = cur_vec[W3_OFF +: W3_W];
    assign wire4 = cur_vec[W4_OFF +: W4_W];

    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign pass      = done && (mismatch_cnt == '0);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_equiv_stim_sched.sv
// Directed and randomized runs of equiv_stim_sched against a vector-list model
// of the scheduler; y_1/y_2 come from a one-cycle-latency stand-in instance pair.
module tb_equiv_stim_sched;

    localparam int          Y_W      = 91;
    localparam int          CNT_W    = 16;
    localparam logic [63:0] DEF_SEED = 64'h1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  start = 1'b0;
    logic                  stop_on_fail = 1'b0;
    logic [63:0]           seed = '0;
    logic [CNT_W-1:0]      num_vec = '0;
    logic [17:0]           wire0;
    logic signed [8:0]     wire1;
    logic signed [7:0]     wire2;
    logic signed [2:0]     wire3;
    logic [10:0]           wire4;
    logic [Y_W-1:0]        y_1 = '0;
    logic [Y_W-1:0]        y_2 = '0;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [CNT_W-1:0]      vec_cnt;
    logic [CNT_W-1:0]      mismatch_cnt;
    logic [CNT_W-1:0]      fail_idx;
    logic [Y_W-1:0]        fail_y1;
    logic [Y_W-1:0]        fail_y2;
    logic [1:0]            dbg_state;

    int checks = 0;
    int errors = 0;

    logic [48:0] mv[$];
    logic [48:0] bad_q[$];
    logic [48:0] seen_q[$];
    logic [48:0] keep_q[$];

    wire [48:0] wv = {wire4, wire3, wire2, wire1, wire0};

    equiv_stim_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop_on_fail (stop_on_fail),
        .seed         (seed),
        .num_vec      (num_vec),
        .wire0        (wire0),
        .wire1        (wire1),
        .wire2        (wire2),
        .wire3        (wire3),
        .wire4        (wire4),
        .y_1          (y_1),
        .y_2          (y_2),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .vec_cnt      (vec_cnt),
        .mismatch_cnt (mismatch_cnt),
        .fail_idx     (fail_idx),
        .fail_y1      (fail_y1),
        .fail_y2      (fail_y2),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // Polynomial x^64+x^63+x^61+x^60+1, stepped to the right.
    function automatic logic [63:0] model_next(input logic [63:0] s);
        logic [63:0] taps;
        taps = '0;
        taps[63] = 1'b1;
        taps[62] = 1'b1;
        taps[60] = 1'b1;
        taps[59] = 1'b1;
        return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
    endfunction

    function automatic logic [Y_W-1:0] resp(input logic [48:0] v);
        return {v[41:0], v};
    endfunction

    function automatic logic is_bad(input logic [48:0] v);
        foreach (bad_q[i]) begin
            if (bad_q[i] == v) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Stand-in instance pair: registered response, y_2 flips bit 0 on marked vectors.
    always @(posedge clk) begin
        y_1 <= resp(wv);
        y_2 <= resp(wv) ^ {{(Y_W-1){1'b0}}, is_bad(wv)};
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic prep(input logic [63:0] s, input int n);
        logic [63:0] st;
        mv = {};
        bad_q = {};
        st = (s == 64'd0) ? DEF_SEED : s;
        for (int i = 0; i < n; i++) begin
            mv.push_back(st[48:0]);
            st = model_next(st);
        end
    endtask

    task automatic mark_bad(input int idx);
        bad_q.push_back(mv[idx]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_vec_cnt"}, vec_cnt, 0);
        check({tag, "_mm_cnt"}, mismatch_cnt, 0);
        check({tag, "_fail_idx"}, fail_idx, 0);
        check({tag, "_fail_y"}, {fail_y1, fail_y2} == '0, 1);
        check({tag, "_wires"}, wv, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    task automatic run(input string tag, input logic [63:0] s, input int n, input bit sof,
                       input int pulse_at, input int rst_at);
        int edges, ff, exp_mm, exp_vec, last_i, exp_lat, diffs;
        bit stopped, timed_out;
        logic [48:0] hold0, exp_w;
        ff = -1;
        exp_mm = 0;
        for (int i = 0; i < n; i++) begin
            if (is_bad(mv[i])) begin
                if (ff < 0) ff = i;
                exp_mm++;
            end
        end
        stopped = sof && (ff >= 0);
        exp_vec = stopped ? ff + 1 : n;
        if (stopped) exp_mm = 1;
        if (n == 0) last_i = -1;
        else if (stopped) last_i = (ff + 1 < n - 1) ? ff + 1 : n - 1;
        else last_i = n - 1;
        exp_lat = (n == 0) ? 1 : (stopped ? ff + 3 : n + 2);
        seen_q = {};

        @(negedge clk);
        seed = s;
        num_vec = CNT_W'(n);
        stop_on_fail = sof;
        start = 1'b1;
        hold0 = wv;
        @(posedge clk);
        edges = 1;
        timed_out = 1'b0;
        forever begin
            @(negedge clk);
            start = 1'b0;
            if (edges == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_zero({tag, "_midrst"});
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (done) break;
            if (busy) seen_q.push_back(wv);
            if (edges == pulse_at) start = 1'b1;
            if (edges > n + 10) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge clk);
            edges++;
        end

        check({tag, "_timeout"}, timed_out, 0);
        check({tag, "_latency"}, edges, exp_lat);
        check({tag, "_done"}, done, 1);
        check({tag, "_pass"}, pass, exp_mm == 0);
        check({tag, "_vec_cnt"}, vec_cnt, exp_vec);
        check({tag, "_mm_cnt"}, mismatch_cnt, exp_mm);
        check({tag, "_fail_idx"}, fail_idx, (ff >= 0) ? ff : 0);
        check({tag, "_fail_y1"}, fail_y1, (ff >= 0) ? resp(mv[ff]) : '0);
        check({tag, "_fail_y2"}, fail_y2, (ff >= 0) ? (resp(mv[ff]) ^ 1) : '0);
        check({tag, "_busy_len"}, seen_q.size(), exp_lat - 1);
        diffs = 0;
        foreach (seen_q[i]) begin
            exp_w = mv[(i < last_i) ? i : last_i];
            if (seen_q[i] !== exp_w) diffs++;
        end
        check({tag, "_wire_seq"}, diffs, 0);
        repeat (3) @(negedge clk);
        exp_w = (last_i < 0) ? hold0 : mv[last_i];
        check({tag, "_hold"}, wv, exp_w);
        check({tag, "_state"}, dbg_state, 3);
    endtask

    initial begin
        int n, diffs, k;
        logic [63:0] rs;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        prep(64'h1, 100);
        run("ident100", 64'h1, 100, 1'b0, -1, -1);

        prep(64'h1, 64);
        mark_bad(37);
        run("glitch37", 64'h1, 64, 1'b0, -1, -1);

        prep(64'h1, 64);
        mark_bad(37);
        run("stop37", 64'h1, 64, 1'b1, -1, -1);

        prep(64'h0, 20);
        run("seed0", 64'h0, 20, 1'b0, -1, -1);
        keep_q = seen_q;
        prep(DEF_SEED, 20);
        run("seeddef", DEF_SEED, 20, 1'b0, -1, -1);
        diffs = (keep_q.size() == seen_q.size()) ? 0 : 1;
        foreach (keep_q[i]) if (i < seen_q.size() && keep_q[i] !== seen_q[i]) diffs++;
        check("seed0_vs_def", diffs, 0);

        prep(64'hDEADBEEF, 10);
        run("beef_a", 64'hDEADBEEF, 10, 1'b0, -1, -1);
        keep_q = seen_q;
        run("beef_b", 64'hDEADBEEF, 10, 1'b0, -1, -1);
        diffs = (keep_q.size() == seen_q.size()) ? 0 : 1;
        foreach (keep_q[i]) if (i < seen_q.size() && keep_q[i] !== seen_q[i]) diffs++;
        check("beef_replay", diffs, 0);

        prep(64'h5, 0);
        run("nvec0", 64'h5, 0, 1'b0, -1, -1);

        prep(64'h1234, 50);
        run("start_mid", 64'h1234, 50, 1'b0, 25, -1);
        prep(64'h77, 30);
        mark_bad(29);
        run("start_final", 64'h77, 30, 1'b0, 31, -1);

        prep(64'h1, 50);
        run("rst_mid", 64'h1, 50, 1'b0, -1, 21);
        run("after_rst", 64'h1, 50, 1'b0, -1, -1);

        for (int r = 0; r < 8; r++) begin
            rs = {$urandom(), $urandom()};
            n = $urandom_range(1, 120);
            prep(rs, n);
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) mark_bad($urandom_range(0, n - 1));
            run($sformatf("rand%0d", r), rs, n, 1'($urandom_range(0, 1)),
                (r % 2 == 0) ? $urandom_range(2, n + 1) : -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/equiv_stim_sched.md
Name: equiv_stim_sched

Overview:
- Self-checking stimulus scheduler and comparator for the dual-instance equivalence harness (top_1 / top_2 pair).
- Generates pseudo-random input vectors for both instances on the shared input bus and aligns the two y outputs by pipeline latency.
- Compares y_1 against y_2 per vector, counts mismatches and captures the first failing vector.
- Replaces free-running stimulus with a deterministic, seed-replayable, length-bounded run.

Parameters:
- Y_W, 91, width of y_1/y_2.
- LAT, 1, cycles from a vector on the wire* outputs to its y response; allowed range 0..7.
- CNT_W, 16, width of the vector-count and mismatch counters.
- DEF_SEED, 64'h1, seed used when the seed input is zero.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse, begins a run (honoured in IDLE/DONE only).
- stop_on_fail  in  1  sampled at start; 1 = end run at first mismatch.
- seed  in  64  LFSR seed, sampled at start.
- num_vec  in  CNT_W  vectors to issue, sampled at start; 0 = immediate DONE, pass.
- wire0  out  18  stimulus bits [17:0] of the LFSR state.
- wire1  out  9  stimulus bits [26:18], signed field.
- wire2  out  8  stimulus bits [34:27], signed field.
- wire3  out  3  stimulus bits [37:35], signed field.
- wire4  out  11  stimulus bits [48:38].
- y_1, y_2  in  Y_W  instance responses.
- busy  out  1  high in RUN/DRAIN.
- done  out  1  high in DONE; held until next start.
- pass  out  1  done & (mismatch_cnt==0).
- vec_cnt  out  CNT_W  vectors compared so far.
- mismatch_cnt  out  CNT_W  compares with y_1!=y_2; saturates at all-ones.
- fail_idx  out  CNT_W  index of first mismatching vector.
- fail_y1, fail_y2  out  Y_W  y values captured at the first mismatch.

Behaviour:
- Reset: FSM=IDLE; all outputs 0; LFSR=DEF_SEED; pipeline valid bits cleared.
- Reset mid-run aborts immediately; no partial results are kept.
- FSM states and transitions:
  - IDLE/DONE --start--> RUN. Latches num_vec, stop_on_fail, seed (zero seed is replaced by DEF_SEED). Clears counters, fail_* and the pipeline.
  - RUN: each cycle presents one vector (current LFSR state, bits [48:0]), then advances the LFSR.
  - RUN --after num_vec issues--> DRAIN.
  - DRAIN --pipeline empty (LAT cycles)--> DONE.
  - RUN/DRAIN --mismatch & stop_on_fail--> DONE next cycle. No further issues; in-flight vectors are discarded.
- LFSR: 64-bit Galois, polynomial x^64+x^63+x^61+x^60+1, shift right one step per issued vector.
- Outputs hold the last vector when not in RUN.
- Alignment: issue index and valid travel through an LAT-deep shift register.
  - A compare happens in the cycle the delayed valid is high, using the y values present in that cycle.
  - With LAT=0 the compare is in the issue cycle.
- On compare: vec_cnt++. If y_1!=y_2 (full Y_W compare), mismatch_cnt++ (saturating).
- On the first mismatch only, capture fail_idx, fail_y1 and fail_y2.
- start while busy is ignored. start in the same cycle as a final compare is ignored (still busy).
- num_vec = 2^CNT_W-1 is legal; vec_cnt never wraps during a run.

Decomposition:
- Package equiv_pkg:
  - LFSR polynomial constant and DEF_SEED.
  - Field offset/width constants for wire0..wire4 (18/9/8/3/11, total 49).
  - FSM state enum {IDLE, RUN, DRAIN, DONE}.
- Sub-module equiv_lfsr64 (seed load, step enable, 64-bit state out); the FSM, latency pipe and compare logic stay in the top.

Test Plan:
- Identical y (y_2 tied to y_1), num_vec=100, LAT=1, seed=1 -> after 102 cycles done=1, pass=1, vec_cnt=100, mismatch_cnt=0.
- y_2 = y_1 ^ 1 when internal index==37, stop_on_fail=0, num_vec=64 -> mismatch_cnt=1, fail_idx=37, fail_y2 bit0 inverted vs fail_y1, vec_cnt=64.
- Same as previous case with stop_on_fail=1 -> done asserted the cycle after compare 37, vec_cnt=38, no vector issued after the stop.
- seed=0 vs seed=DEF_SEED -> identical wire0..wire4 sequences. Two runs with seed=64'hDEADBEEF -> identical first 10 vectors.
- num_vec=0 -> DONE one cycle after start, pass=1, no vector issued. start pulsed during RUN -> counters unaffected.
- rst_n low at vector 20 of 50 -> all outputs 0, IDLE; a subsequent start runs a clean 50-vector pass.
